// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the CPU's MAR/MBR bus. One read or write is
// accepted per req/ack handshake. After acceptance the request is held in
// latched copies for WAIT_CYCLES wait states. It is then committed against
// an internal DEPTH x DATA_W register-array RAM. A one-cycle ack pulse
// closes the transaction. The CPU side loads its MBR with
// MEM_ack & ~MEM_we_q.
//
// Ports
//   MEM_clk    in   1       clock, everything on posedge
//   MEM_rst    in   1       synchronous active-high reset (RAM is kept)
//   MEM_req    in   1       request valid, only looked at while idle
//   MEM_we     in   1       1 = write, 0 = read, sampled with MEM_req
//   MEM_addr   in   ADDR_W  word address, sampled with MEM_req
//   MEM_wdata  in   DATA_W  write data, sampled with MEM_req
//   MEM_rdata  out  DATA_W  read data, holds until the next completed read
//   MEM_ack    out  1       one-cycle completion pulse
//   MEM_err    out  1       out-of-range flag, pulses together with MEM_ack
//   MEM_busy   out  1       high from the cycle after acceptance through ack
//   MEM_we_q   out  1       direction of the current or last transaction
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              MEM_clk,
    input  logic              MEM_rst,
    input  logic              MEM_req,
    input  logic              MEM_we,
    input  logic [ADDR_W-1:0] MEM_addr,
    input  logic [DATA_W-1:0] MEM_wdata,
    output logic [DATA_W-1:0] MEM_rdata,
    output logic              MEM_ack,
    output logic              MEM_err,
    output logic              MEM_busy,
    output logic              MEM_we_q
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    // The index only needs enough bits to cover the implemented words.
    // Out-of-range addresses never reach the array because the range check
    // gates both the read and the write.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH can equal 2**ADDR_W, so the compare needs one extra bit.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // With zero wait states the WAIT state is skipped entirely, so the
    // loaded counter value does not matter. Clamp it to avoid an underflow.
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_wr_en;
    logic              in_range;
    logic [IDX_W-1:0]  mem_idx;

    assign in_range = ({1'b0, addr_q} < DEPTH_L);
    assign mem_idx  = addr_q[IDX_W-1:0];

    // Next-state and registered-output logic. ACCESS is the commit edge:
    // only there does the RAM change or MEM_rdata update. A reset before
    // that edge therefore leaves the RAM untouched.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ack_d     = ack_q;
        err_d     = err_q;
        busy_d    = busy_q;
        mem_wr_en = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (MEM_req) begin
                    we_d    = MEM_we;
                    addr_d  = MEM_addr;
                    wdata_d = MEM_wdata;
                    busy_d  = 1'b1;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: begin
                ack_d   = 1'b1;
                err_d   = ~in_range;
                state_d = RESP;
                if (we_q) begin
                    mem_wr_en = in_range;
                end else begin
                    rdata_d = in_range ? mem_q[mem_idx] : {DATA_W{1'b1}};
                end
            end
            RESP: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge MEM_clk) begin
        if (MEM_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // The RAM has no reset. Its contents survive MEM_rst, which still blocks
    // a pending write because it holds the FSM out of ACCESS.
    always_ff @(posedge MEM_clk) begin
        if (mem_wr_en && !MEM_rst) begin
            mem_q[mem_idx] <= wdata_q;
        end
    end

    assign MEM_rdata = rdata_q;
    assign MEM_ack   = ack_q;
    assign MEM_err   = err_q;
    assign MEM_busy  = busy_q;
    assign MEM_we_q  = we_q;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Two responders share one clock and one reset:
//   dut 0: WAIT_CYCLES=2, DEPTH=256
//   dut 1: WAIT_CYCLES=0, DEPTH=16
// A transaction-level model predicts the results. It holds a word array
// per instance and the last read value. The expected ack latency is
// WAIT_CYCLES+1 edges after the accepting edge.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam int WC0  = 2;
    localparam int DEP0 = 256;
    localparam int WC1  = 0;
    localparam int DEP1 = 16;

    logic       clk;
    logic       rst;
    logic       req   [2];
    logic       we    [2];
    logic [7:0] addr  [2];
    logic [7:0] wdata [2];
    logic [7:0] rdata [2];
    logic       ack   [2];
    logic       err   [2];
    logic       busy  [2];
    logic       weQ   [2];

    int         waitCycles [2];
    int         depth      [2];
    logic [7:0] modelMem   [2][256];
    logic [7:0] lastRd     [2];

    int checks;
    int errors;

    mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEP0), .WAIT_CYCLES(WC0)) dut0 (
        .MEM_clk(clk), .MEM_rst(rst), .MEM_req(req[0]), .MEM_we(we[0]),
        .MEM_addr(addr[0]), .MEM_wdata(wdata[0]), .MEM_rdata(rdata[0]),
        .MEM_ack(ack[0]), .MEM_err(err[0]), .MEM_busy(busy[0]), .MEM_we_q(weQ[0])
    );

    mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEP1), .WAIT_CYCLES(WC1)) dut1 (
        .MEM_clk(clk), .MEM_rst(rst), .MEM_req(req[1]), .MEM_we(we[1]),
        .MEM_addr(addr[1]), .MEM_wdata(wdata[1]), .MEM_rdata(rdata[1]),
        .MEM_ack(ack[1]), .MEM_err(err[1]), .MEM_busy(busy[1]), .MEM_we_q(weQ[1])
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // The model's view of one completed access: returns the expected error
    // flag and updates the word array and the last read value.
    task automatic modelAccess(input int d, input bit isWrite, input logic [7:0] a,
                               input logic [7:0] wd, output bit expErr);
        expErr = (int'(a) >= depth[d]);
        if (isWrite) begin
            if (!expErr) modelMem[d][a] = wd;
        end else begin
            lastRd[d] = expErr ? 8'hFF : modelMem[d][a];
        end
    endtask

    // One complete handshake on instance d. Inputs are scrambled right after
    // acceptance, so only the latched copies can produce the right answer.
    task automatic applyStimulus(input int d, input bit isWrite, input logic [7:0] a,
                                 input logic [7:0] wd);
        int n;
        bit expErr;
        bit busyDropped;
        @(negedge clk);
        req[d]   = 1'b1;
        we[d]    = isWrite;
        addr[d]  = a;
        wdata[d] = wd;
        @(posedge clk);
        #1;
        req[d]   = 1'b0;
        we[d]    = 1'($urandom);
        addr[d]  = 8'($urandom);
        wdata[d] = 8'($urandom);
        checkOutput("busyAfterAccept", 32'(busy[d]), 32'd1);
        n = 0;
        busyDropped = 1'b0;
        while (!ack[d] && n <= 20) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy[d]) busyDropped = 1'b1;
        end
        checkOutput("ackLatency", 32'(n), 32'(waitCycles[d] + 1));
        if (n > 20) return;
        modelAccess(d, isWrite, a, wd, expErr);
        checkOutput("busyHeld", 32'(busyDropped), 32'd0);
        checkOutput("errWithAck", 32'(err[d]), 32'(expErr));
        checkOutput("weQ", 32'(weQ[d]), 32'(isWrite));
        checkOutput("rdata", 32'(rdata[d]), 32'(lastRd[d]));
        @(posedge clk);
        #1;
        checkOutput("ackPulseEnd", 32'(ack[d]), 32'd0);
        checkOutput("busyEnd", 32'(busy[d]), 32'd0);
        checkOutput("errEnd", 32'(err[d]), 32'd0);
    endtask

    // With req held high on dut 0, reads repeat once every WAIT_CYCLES+3
    // cycles. Twenty cycles of request give four complete accesses.
    task automatic holdHighTest(input logic [7:0] a);
        int ackCount;
        int prevAck;
        bit expErr;
        ackCount = 0;
        prevAck  = -1;
        @(negedge clk);
        req[0]  = 1'b1;
        we[0]   = 1'b0;
        addr[0] = a;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (ack[0]) begin
                modelAccess(0, 1'b0, a, 8'h00, expErr);
                checkOutput("holdRdata", 32'(rdata[0]), 32'(lastRd[0]));
                if (prevAck >= 0) checkOutput("holdSpacing", 32'(c - prevAck), 32'(WC0 + 3));
                prevAck = c;
                ackCount++;
            end
        end
        @(negedge clk);
        req[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("holdAckCount", 32'(ackCount), 32'd4);
        checkOutput("holdIdle", 32'(busy[0]), 32'd0);
    endtask

    // A write on dut 0 is killed by reset during its wait states. The reset
    // must block the write and the ack, and the old word must survive.
    task automatic resetMidWriteTest();
        int lateAcks;
        applyStimulus(0, 1'b1, 8'h05, 8'h11);
        @(negedge clk);
        req[0]   = 1'b1;
        we[0]    = 1'b1;
        addr[0]  = 8'h05;
        wdata[0] = 8'h77;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midRstAck", 32'(ack[0]), 32'd0);
        checkOutput("midRstBusy", 32'(busy[0]), 32'd0);
        checkOutput("midRstRdata", 32'(rdata[0]), 32'd0);
        checkOutput("midRstWeQ", 32'(weQ[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lastRd[0] = 8'h00;
        lastRd[1] = 8'h00;
        lateAcks = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ack[0]) lateAcks++;
        end
        checkOutput("midRstNoAck", 32'(lateAcks), 32'd0);
        applyStimulus(0, 1'b0, 8'h05, 8'h00);
        checkOutput("midRstKeep", 32'(rdata[0]), 32'h11);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        waitCycles[0] = WC0;
        waitCycles[1] = WC1;
        depth[0] = DEP0;
        depth[1] = DEP1;
        for (int d = 0; d < 2; d++) begin
            req[d]   = 1'b0;
            we[d]    = 1'b0;
            addr[d]  = 8'h00;
            wdata[d] = 8'h00;
            lastRd[d] = 8'h00;
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput("rstRdata", 32'(rdata[d]), 32'd0);
            checkOutput("rstAck", 32'(ack[d]), 32'd0);
            checkOutput("rstBusy", 32'(busy[d]), 32'd0);
            checkOutput("rstErr", 32'(err[d]), 32'd0);
            checkOutput("rstWeQ", 32'(weQ[d]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Give every implemented word a known value before any random read.
        for (int i = 0; i < DEP0; i++) applyStimulus(0, 1'b1, 8'(i), 8'($urandom));
        for (int i = 0; i < DEP1; i++) applyStimulus(1, 1'b1, 8'(i), 8'($urandom));

        // Write then read back with two wait states.
        applyStimulus(0, 1'b1, 8'h10, 8'hA5);
        applyStimulus(0, 1'b0, 8'h10, 8'h00);
        checkOutput("readBackA5", 32'(rdata[0]), 32'hA5);

        // Zero wait states: the read completes on the second edge.
        applyStimulus(1, 1'b1, 8'h00, 8'h3C);
        applyStimulus(1, 1'b0, 8'h00, 8'h00);
        checkOutput("readBack3C", 32'(rdata[1]), 32'h3C);

        // Out-of-range accesses against the 16-word instance.
        applyStimulus(1, 1'b1, 8'h20, 8'h20);
        applyStimulus(1, 1'b0, 8'h20, 8'h00);
        checkOutput("oorReadFF", 32'(rdata[1]), 32'hFF);
        applyStimulus(1, 1'b0, 8'h00, 8'h00);
        checkOutput("oorNoWrite", 32'(rdata[1]), 32'h3C);

        // Random traffic. Addresses for dut 1 span twice its depth, so about
        // half of its accesses go out of range.
        for (int k = 0; k < 150; k++) begin
            applyStimulus(0, 1'($urandom), 8'($urandom), 8'($urandom));
            applyStimulus(1, 1'($urandom), 8'($urandom_range(31, 0)), 8'($urandom));
        end

        holdHighTest(8'h10);
        resetMidWriteTest();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
